// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the serial shift-add multiplier responder.
package seq_mult_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned CntWidth     = $clog2(DefaultWidth);

  typedef enum logic [1:0] {
    StIdle,
    StLoaded,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/shift_add_dp.sv
// Serial shift-add datapath: one multiplier bit per step.
// SEQ_MULT_SIGNED_EN adds magnitude loading and sign correction of the result.
module shift_add_dp
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d, a_mag, b_mag;
  logic [CntW-1:0]    cnt_q, cnt_d;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is correct as unsigned.
  assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;
`else
  assign a_mag = a_i;
  assign b_mag = b_i;
`endif

  // Sum including the current step, so the exiting edge captures the final bit.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_o  = (cnt_q == CntW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  assign result_o = sign_q ? -acc_sum : acc_sum;
`else
  assign result_o = acc_sum;
`endif

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef SEQ_MULT_SIGNED_EN
    sign_d   = sign_q;
`endif
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`endif
    end else if (step_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

endmodule

// File: rtl/seq_mult_responder.sv
// Operand/result handshake responder around a serial shift-add multiplier.
// Define SEQ_MULT_SIGNED_EN for two's complement operands.
module seq_mult_responder
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_signal,
  input  logic                 start_calc,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   read_data,
  output logic                 ready_signal,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] rdata_q, rdata_d, dp_result;
  logic               ready_q, ready_d;
  logic               dp_load, dp_step, dp_last;

  shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .a_i      (a_q),
    .b_i      (b_q),
    .last_o   (dp_last),
    .result_o (dp_result)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_signal) begin
          a_d     = A;
          b_d     = B;
          state_d = StLoaded;
        end
      end
      StLoaded: begin
        // Start wins over a simultaneous re-load.
        if (start_calc) begin
          dp_load = 1'b1;
          state_d = StBusy;
        end else if (valid_signal) begin
          a_d = A;
          b_d = B;
        end
      end
      StBusy: begin
        dp_step = 1'b1;
        if (dp_last) begin
          rdata_d = dp_result;
          ready_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // A held start must not retrigger; only a new load leaves DONE.
        if (valid_signal) begin
          a_d     = A;
          b_d     = B;
          ready_d = 1'b0;
          state_d = StLoaded;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign read_data    = rdata_q;
  assign ready_signal = ready_q;
  assign busy         = (state_q == StBusy);

endmodule

// File: tb/tb_seq_mult_responder.sv
// Directed self-checking bench for seq_mult_responder (WIDTH = 16).
module tb_seq_mult_responder;

  logic        clk;
  logic        rst_n;
  logic        valid_signal;
  logic        start_calc;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] read_data;
  logic        ready_signal;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_responder #(
    .WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_signal (valid_signal),
    .start_calc   (start_calc),
    .A            (A),
    .B            (B),
    .read_data    (read_data),
    .ready_signal (ready_signal),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    valid_signal = 1'b1;
    A            = a;
    B            = b;
    tick();
    valid_signal = 1'b0;
  endtask

  // Counts edges until ready rises (bounded); edge 1 is the one that samples start.
  task automatic wait_ready(output int edges, output int bcnt);
    edges = 0;
    bcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      edges++;
      if (busy) bcnt++;
      if (ready_signal) break;
    end
  endtask

  task automatic start_and_wait(output int lat, output int bcnt);
    int edges;
    start_calc = 1'b1;
    wait_ready(edges, bcnt);
    lat = edges - 1;
  endtask

  task automatic run_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
    int lat, bcnt;
    start_calc = 1'b0;
    load_ops(a, b);
    start_and_wait(lat, bcnt);
    start_calc = 1'b0;
    check_eq({tag, "_lat"}, 64'(lat), 64'd16);
    check_eq({tag, "_data"}, 64'(read_data), 64'(exp));
    check_eq({tag, "_ready"}, 64'(ready_signal), 64'd1);
  endtask

  initial begin
    int lat, bcnt, edges;
    rst_n        = 1'b1;
    valid_signal = 1'b0;
    start_calc   = 1'b0;
    A            = '0;
    B            = '0;
    #3 rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst_data", 64'(read_data), 64'd0);
    check_eq("rst_ready", 64'(ready_signal), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // Start alone in IDLE is ignored.
    start_calc = 1'b1;
    tick();
    tick();
    check_eq("idle_start_busy", 64'(busy), 64'd0);
    start_calc = 1'b0;

    // Case 1: 24*30 with start held through and after completion.
    load_ops(16'd24, 16'd30);
    start_and_wait(lat, bcnt);
    check_eq("c1_lat", 64'(lat), 64'd16);
    check_eq("c1_busy_cycles", 64'(bcnt), 64'd16);
    check_eq("c1_data", 64'(read_data), 64'd720);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("c1_hold_ready", 64'(ready_signal), 64'd1);
      check_eq("c1_hold_busy", 64'(busy), 64'd0);
    end
    check_eq("c1_hold_data", 64'(read_data), 64'd720);
    start_calc = 1'b0;

    // Case 3: new load drops ready but keeps old data.
    load_ops(16'd0, 16'd1234);
    check_eq("c3_ready_drop", 64'(ready_signal), 64'd0);
    check_eq("c3_data_kept", 64'(read_data), 64'd720);
    start_and_wait(lat, bcnt);
    start_calc = 1'b0;
    check_eq("c3_lat", 64'(lat), 64'd16);
    check_eq("c3_data", 64'(read_data), 64'd0);
    check_eq("c3_ready", 64'(ready_signal), 64'd1);

`ifndef SEQ_MULT_SIGNED_EN
    // Case 2: maximum operands.
    load_ops(16'hFFFF, 16'hFFFF);
    start_and_wait(lat, bcnt);
    start_calc = 1'b0;
    check_eq("c2_data", 64'(read_data), 64'hFFFE0001);
    check_eq("c2_busy_cycles", 64'(bcnt), 64'd16);
    check_eq("c2_lat", 64'(lat), 64'd16);
`endif

    // Case 5: valid during BUSY is ignored.
    load_ops(16'd24, 16'd30);
    start_calc = 1'b1;
    tick();
    start_calc = 1'b0;
    check_eq("c5_busy", 64'(busy), 64'd1);
    tick();
    tick();
    valid_signal = 1'b1;
    A            = 16'd5;
    tick();
    tick();
    valid_signal = 1'b0;
    wait_ready(edges, bcnt);
    check_eq("c5_edges", 64'(edges), 64'd12);
    check_eq("c5_data", 64'(read_data), 64'd720);
    run_case("c5_next", 16'd5, 16'd30, 32'd150);

    // Case 4: reset during the 8th BUSY cycle.
    load_ops(16'd24, 16'd30);
    start_calc = 1'b1;
    tick();
    start_calc = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_eq("c4_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("c4_rst_data", 64'(read_data), 64'd0);
    check_eq("c4_rst_ready", 64'(ready_signal), 64'd0);
    check_eq("c4_rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_case("c4_after", 16'd5, 16'd7, 32'd35);

`ifdef SEQ_MULT_SIGNED_EN
    // Case 6: signed operands.
    run_case("c6_m3x7", 16'hFFFD, 16'd7, 32'hFFFFFFEB);
    run_case("c6_minxmin", 16'h8000, 16'h8000, 32'h40000000);
    run_case("c6_m1xm1", 16'hFFFF, 16'hFFFF, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
